// File: rtl/oser10_pkg.sv
// Shared constants for the OSER10 word-rate sequencer: state encoding,
// divider phase limit and default idle/training words.
package oser10_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_TRAIN  = 2'd2,
      ST_RUN    = 2'd3
   } state_e;

   localparam logic [2:0]  PH_LAST          = 3'd4;
   localparam logic [9:0]  DEF_IDLE_WORD    = 10'b1010101010;
   localparam logic [9:0]  DEF_TRAIN_WORD   = 10'b0000011111;
   localparam int unsigned DEF_TRAIN_WORDS  = 16;
   localparam int unsigned DEF_WARMUP_PCLKS = 4;
   localparam int unsigned DEF_RST_PCLKS    = 2;

endpackage

// File: rtl/oser10_pclk_div.sv
// Divide-by-5 PCLK generator for OSER10; the negedge flop stretches the
// high time to 2.5 FCLK cycles. Exports the word-boundary strobe (ph == 4).
module oser10_pclk_div
   import oser10_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   output logic pclk_o,
   output logic boundary_o
);

   logic [2:0] ph_q, ph_d;
   logic       b_q;

   always_comb begin
      ph_d = (ph_q == PH_LAST) ? 3'd0 : ph_q + 3'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph_q <= 3'd0;
      end else begin
         ph_q <= ph_d;
      end
   end

   // Half-cycle delayed copy of ph[1] extends PCLK high into the ph==4 cycle.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_q <= 1'b0;
      end else begin
         b_q <= ph_q[1];
      end
   end

   assign pclk_o     = ph_q[1] | b_q;
   assign boundary_o = (ph_q == PH_LAST);

endmodule

// File: rtl/oser10_word_sched.sv
// Word-rate sequencer for an OSER10 lane: reset hold, warm-up, training, then
// valid/ready streaming. Define OSER10_SCHED_UNDERRUN_CNT_EN for underrun_cnt.
module oser10_word_sched
   import oser10_pkg::*;
#(
   parameter logic [9:0]  IDLE_WORD    = DEF_IDLE_WORD,
   parameter logic [9:0]  TRAIN_WORD   = DEF_TRAIN_WORD,
   parameter int unsigned TRAIN_WORDS  = DEF_TRAIN_WORDS,
   parameter int unsigned WARMUP_PCLKS = DEF_WARMUP_PCLKS,
   parameter int unsigned RST_PCLKS    = DEF_RST_PCLKS
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [9:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        pclk_o,
   output logic        oser_rst_o,
   output logic [9:0]  d_o,
   output logic [1:0]  state_o,
   output logic        underrun_o
`ifdef OSER10_SCHED_UNDERRUN_CNT_EN
   ,
   output logic [15:0] underrun_cnt
`endif
);

   localparam logic [7:0] RST_LAST   = 8'(RST_PCLKS - 1);
   localparam logic [7:0] WARMUP_LAST = 8'(WARMUP_PCLKS - 1);
   localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_WORDS - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [9:0] word_q, word_d;
   logic       underrun_q, underrun_d;
   logic       boundary;

   oser10_pclk_div u_pclk_div (
      .clk        (clk),
      .rst_n      (rst_i),
      .pclk_o     (pclk_o),
      .boundary_o (boundary)
   );

   assign in_ready = boundary && (state_q == ST_RUN) && en_i;

   // Everything below only moves at the word boundary; en_i low overrides any terminal count.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      underrun_d = 1'b0;
      if (boundary) begin
         if (!en_i) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
            word_d  = IDLE_WORD;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  word_d = IDLE_WORD;
                  if (cnt_q == RST_LAST) begin
                     state_d = ST_WARMUP;
                     cnt_d   = 8'd0;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
               ST_WARMUP: begin
                  if (cnt_q == WARMUP_LAST) begin
                     state_d = ST_TRAIN;
                     cnt_d   = 8'd0;
                     word_d  = TRAIN_WORD;
                  end else begin
                     cnt_d  = cnt_q + 8'd1;
                     word_d = IDLE_WORD;
                  end
               end
               ST_TRAIN: begin
                  if (cnt_q == TRAIN_LAST) begin
                     state_d = ST_RUN;
                     cnt_d   = 8'd0;
                     word_d  = IDLE_WORD;
                  end else begin
                     cnt_d  = cnt_q + 8'd1;
                     word_d = TRAIN_WORD;
                  end
               end
               ST_RUN: begin
                  if (in_valid) begin
                     word_d = in_data;
                  end else begin
                     word_d     = IDLE_WORD;
                     underrun_d = 1'b1;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  cnt_d   = 8'd0;
                  word_d  = IDLE_WORD;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 8'd0;
         word_q     <= IDLE_WORD;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         underrun_q <= underrun_d;
      end
   end

   assign state_o    = state_q;
   assign oser_rst_o = (state_q == ST_IDLE);
   assign d_o        = word_q;
   assign underrun_o = underrun_q;

`ifdef OSER10_SCHED_UNDERRUN_CNT_EN
   logic [15:0] ucnt_q, ucnt_d;

   // Counts alongside the underrun pulse; restarts each time training begins.
   always_comb begin
      ucnt_d = ucnt_q;
      if (state_d == ST_TRAIN && state_q != ST_TRAIN) begin
         ucnt_d = 16'd0;
      end else if (underrun_d && ucnt_q != 16'hFFFF) begin
         ucnt_d = ucnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         ucnt_q <= 16'd0;
      end else begin
         ucnt_q <= ucnt_d;
      end
   end

   assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: doc/oser10_word_sched.md
Name: oser10_word_sched

Overview:
Word-rate sequencer for an OSER10 + ELVDS_TBUF serial lane, clocked by the fast serial clock (FCLK).
- Generates the divide-by-5 PCLK for OSER10.
- Drives the OSER10 RESET input.
- Runs a fixed startup sequence (reset hold, warm-up, training) before streaming words.
- Accepts 10-bit words from a valid/ready source, one per PCLK period.
- Sits between the user word source and the OSER10 D0..D9/PCLK/RESET pins.

Parameters:
IDLE_WORD, 10'b1010101010, word sent when no data is available; D0 = bit 0.
TRAIN_WORD, 10'b0000011111, training word sent during TRAIN.
TRAIN_WORDS, 16, number of training words (1..255).
WARMUP_PCLKS, 4, PCLK periods of IDLE_WORD after RESET release (1..15).
RST_PCLKS, 2, PCLK periods that oser_rst_o is held high (1..15).

Ports:
clk  in  1  fast serial clock (FCLK), shared with OSER10.FCLK
rst_i  in  1  asynchronous active-low reset
en_i  in  1  lane enable, level-sensitive
in_data  in  10  word to serialize; bit 0 goes to D0
in_valid  in  1  in_data valid
in_ready  out  1  word-boundary accept strobe
pclk_o  out  1  divide-by-5 PCLK to OSER10.PCLK
oser_rst_o  out  1  OSER10 RESET, active-high
d_o  out  10  parallel word to OSER10 D0..D9
state_o  out  2  0=IDLE 1=WARMUP 2=TRAIN 3=RUN
underrun_o  out  1  one-clk pulse on a RUN boundary with no valid word

Behaviour:
Divider:
- Phase counter ph runs 0..4 and wraps 4→0 on every clk.
- pclk_o = ph[1] OR b, where b is a negedge-clk flop sampling ph[1].
- Result: pclk_o is high for 2.5 clk cycles of every 5.
- ph counts continuously in every state, including when en_i=0.

Word boundary:
- The boundary is the clk edge where ph goes 4→0.
- d_o, the state machine and all state counters update only at boundaries.
- d_o is stable from 2 clk before the pclk_o rising edge.

Handshake:
- in_ready=1 only when ph==4 and state==RUN and en_i==1.
- Transfer occurs when in_valid && in_ready; in_data is loaded into d_o at that boundary (latency 1 clk).
- in_valid may be held across periods; a source without a transfer keeps its word.
- RUN boundary with in_valid=0: d_o<=IDLE_WORD and underrun_o pulses for exactly 1 clk (the ph==0 cycle).

State machine (all transitions at boundaries):
- IDLE: oser_rst_o=1, d_o=IDLE_WORD. Leave after en_i=1 has been seen and RST_PCLKS periods have been counted, going to WARMUP.
- WARMUP: oser_rst_o=0, d_o=IDLE_WORD for WARMUP_PCLKS periods, then go to TRAIN. This covers the OSER10 4-cycle start latency.
- TRAIN: d_o=TRAIN_WORD for TRAIN_WORDS periods, then go to RUN.
- RUN: streams words as described under Handshake.
- en_i=0 in any non-IDLE state: go to IDLE at the next boundary and reload the reset counter. No in_ready is issued at that boundary.

Reset (rst_i low, asynchronous), all outputs forced immediately:
- ph=0, b=0, pclk_o=0.
- state=IDLE, oser_rst_o=1, d_o=IDLE_WORD.
- in_ready=0, underrun_o=0, all counters 0.
- rst_i low mid-word drops the word; the source must re-present it.
- Release is asynchronous; the first boundary comes 5 clk after release.

Simultaneous events:
- en_i falling in the same ph==4 cycle as in_valid: no transfer, because in_ready is already gated.
- Counter terminal count and en_i=0 on the same boundary: IDLE wins.

Optional Feature:
OSER10_SCHED_UNDERRUN_CNT_EN.
- Defined: adds output underrun_cnt[15:0], incremented on each underrun_o pulse. It saturates at 16'hFFFF, clears on rst_i, and clears on entry to TRAIN.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package oser10_pkg: state encoding constants (IDLE/WARMUP/TRAIN/RUN = 2'd0..3), PH_LAST=3'd4, default IDLE_WORD and TRAIN_WORD.
- One natural sub-module, oser10_pclk_div: holds ph, the negedge flop and pclk_o, and exports a boundary strobe (ph==4).

Test Plan:
- Reset then en_i=1, defaults:
  - oser_rst_o high for 2 periods.
  - 4 periods of 10'b1010101010.
  - 16 periods of 10'b0000011111.
  - state_o=3 at boundary 22.
- Free-running clk, check pclk_o:
  - period exactly 5 clk.
  - high for 2.5 clk.
  - d_o changes only at ph 4→0, 2 clk before each pclk rise.
- RUN with in_valid held high, words 0x001,0x002,0x3FF:
  - one in_ready per period.
  - d_o shows each word for exactly 5 clk, in order, with no underrun.
- RUN with in_valid low for 3 periods:
  - d_o=IDLE_WORD.
  - 3 underrun_o pulses.
  - underrun_cnt=3 with the macro defined.
- en_i dropped mid-TRAIN, and separately rst_i pulsed mid-RUN:
  - en_i case: IDLE at the next boundary with oser_rst_o=1, then the full sequence restarts from RST_PCLKS.
  - rst_i case: outputs reset immediately.
- in_valid rises in the same cycle en_i falls at ph==4: no transfer and no in_ready; state becomes IDLE.
